systolic_tile_ctrl: RTL
=======================

Name: systolic_tile_ctrl

Overview:
- Sequences one output tile on the 4x4 Q1.15 PE array: clear, skewed operand feed, pipeline flush, drain.
- Fetches operand slices from an operand buffer: column k of A and row k of B, one k per cycle.
- Applies the row/column input skew and drives the array control lines: acc_clr, in_valid, out_phase, drain_step.
- Returns the 16 accumulated results as a ready/valid stream. Sits between the tile scheduler/DMA and the array top.

Parameters:
- N, 4, array dimension; fixed at 4 (drain index is 4 bits).
- BW, 16, operand width (signed Q1.15).
- ACCW, 40, accumulator/result width.
- KW, 8, width of the reduction-length input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  tile start request; sampled only in IDLE.
- k_len  in  KW  reduction length K, captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last result is accepted.
- rd_en  out  1  operand buffer read strobe.
- rd_k  out  KW  operand index k.
- rd_a  in  N*BW  A[0..3][k]; valid the cycle after rd_en.
- rd_b  in  N*BW  B[k][0..3]; valid the cycle after rd_en.
- a_west  out  N*BW  skewed A into array row i (slice i).
- b_north  out  N*BW  skewed B into array column j (slice j).
- v_west  out  N  in_valid for each array row.
- v_north  out  N  valid for each array column; informational.
- acc_clr  out  1  accumulator clear to all PEs.
- out_phase  out  1  drain phase to all PEs.
- drain_step  out  8  drain index to all PEs.
- c_drain  in  ACCW  diagonal-chain tail from the array.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  ACCW  result value.
- res_idx  out  4  result index, row*4+col.

Behaviour:
- Reset: every output 0; FSM in IDLE; all skew registers 0. A reset mid-operation aborts the tile immediately, with no done pulse.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN.
- IDLE: start=1 captures k_len, sets busy, moves to CLEAR. start in any other state is ignored.
- CLEAR: acc_clr=1 for exactly 1 cycle. Next state is FEED, or FLUSH if k_len==0.
- FEED: rd_en=1 and rd_k=0..K-1 on consecutive cycles, K cycles in total, then FLUSH.
- Operand path:
  - Read data arrives 1 cycle after rd_en.
  - Row i of A (and column j of B) passes through an i-stage (j-stage) shift register, so slice i leads the array i cycles after its data returns.
  - Slice 0 is unregistered past the read latency.
  - Valid bits travel through the same skew registers.
  - Data slices are forced to 0 whenever their valid bit is 0.
- FLUSH: fixed 2*N = 8 cycles. This covers the 1-cycle read latency, the 3-cycle skew, 3 hops and the PE register, so PE(3,3) has absorbed its last product. Then DRAIN with drain_step=0.
- DRAIN:
  - out_phase=1 and res_valid=1.
  - res_data=c_drain (combinational pass-through); res_idx=drain_step[3:0].
  - drain_step increments only on res_valid&&res_ready; res_ready=0 holds drain_step and res_* stable.
  - Acceptance at drain_step==15: next cycle is IDLE, done=1 for 1 cycle, busy=0, out_phase=0, drain_step=0.
- Tile latency with no backpressure: 1 + K + 8 + 16 cycles from start acceptance to the done pulse.
- k_len==0 drains 16 zeros.
- acc_clr, out_phase and v_west are never high simultaneously.

Optional Feature:
- CTRL_PERF_CNT_EN defined:
  - Adds output perf_busy_cyc (32): counts cycles with busy=1, saturating.
  - Adds output perf_stall_cyc (32): counts DRAIN cycles with res_ready=0, saturating.
  - Both clear on accepted start and hold their value after done.
- CTRL_PERF_CNT_EN undefined: both ports and the counters are absent; all other behaviour is identical.

Test Plan:
- Identity x B: A=I scaled 0x7FFF, B entries 0x4000, K=4, res_ready=1. Results stream idx 0..15 in order; each equals the sum of 4 Q1.15 products (bit-exact vs model); done 29 cycles after start.
- K=1, A[i]=0x0100*(i+1), B[j]=0x0002: res_data[i*4+j]=0x200*(i+1). v_west[i] is high exactly 1 cycle, at cycle 2+i after start.
- Backpressure: res_ready toggles 1,0,0,1 repeating. Every idx 0..15 appears exactly once and res_data is stable while stalled; with CTRL_PERF_CNT_EN, perf_stall_cyc equals the number of stall cycles.
- start pulsed during FEED and during DRAIN: ignored, no second tile; rd_k never exceeds K-1.
- rst_n asserted at FEED cycle 2: all outputs 0 immediately, no done pulse. A new start then runs a full tile correctly.
- k_len=0: acc_clr 1 cycle, no rd_en, 16 zero results, done 25 cycles after start.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for a 4x4 Q1.15 systolic array: clear, skewed operand feed, flush, result drain.
// Optional CTRL_PERF_CNT_EN adds saturating busy/stall cycle counters.
module systolic_tile_ctrl #(
  parameter int N    = 4,
  parameter int BW   = 16,
  parameter int ACCW = 40,
  parameter int KW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [KW-1:0]     rd_k,
  input  logic [N*BW-1:0]   rd_a,
  input  logic [N*BW-1:0]   rd_b,
  output logic [N*BW-1:0]   a_west,
  output logic [N*BW-1:0]   b_north,
  output logic [N-1:0]      v_west,
  output logic [N-1:0]      v_north,
  output logic              acc_clr,
  output logic              out_phase,
  output logic [7:0]        drain_step,
  input  logic [ACCW-1:0]   c_drain,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACCW-1:0]   res_data,
  output logic [3:0]        res_idx,
  output logic [2:0]        dbg_state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
`endif
);

  // Result handshake: a result moves on a cycle where res_valid && res_ready;
  // while res_ready is low, res_data/res_idx/drain_step hold.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [7:0]    drain_q, drain_d;
  logic          done_q, done_d;
  logic          rd_vld_q, rd_vld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_len_q  <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    rd_vld_d = (state_q == S_FEED);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_len_d = k_len;
          cnt_d   = '0;
          drain_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = (k_len_q == '0) ? S_FLUSH : S_FEED;
      end
      S_FEED: begin
        if (cnt_q == k_len_q - KW'(1)) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_FLUSH: begin
        // Covers read latency, worst-case skew, hops to PE(3,3) and its register.
        if (cnt_q == KW'(2 * N - 1)) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (drain_q == 8'd15) begin
            drain_d = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            drain_d = drain_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign rd_en      = (state_q == S_FEED);
  assign rd_k       = rd_en ? cnt_q : '0;
  assign acc_clr    = (state_q == S_CLEAR);
  assign out_phase  = (state_q == S_DRAIN);
  assign res_valid  = out_phase;
  assign drain_step = drain_q;
  assign res_data   = out_phase ? c_drain : '0;
  assign res_idx    = drain_q[3:0];
  assign dbg_state  = state_q;

  // Slice 0 leads the array directly off the read port.
  assign v_west[0]       = rd_vld_q;
  assign v_north[0]      = rd_vld_q;
  assign a_west[BW-1:0]  = rd_vld_q ? rd_a[BW-1:0] : '0;
  assign b_north[BW-1:0] = rd_vld_q ? rd_b[BW-1:0] : '0;

  for (genvar gi = 1; gi < N; gi++) begin : g_skew
    logic [BW-1:0] a_sk_q [0:gi-1];
    logic [BW-1:0] a_sk_d [0:gi-1];
    logic [BW-1:0] b_sk_q [0:gi-1];
    logic [BW-1:0] b_sk_d [0:gi-1];
    logic          v_sk_q [0:gi-1];
    logic          v_sk_d [0:gi-1];

    always_comb begin
      a_sk_d[0] = rd_a[gi*BW +: BW];
      b_sk_d[0] = rd_b[gi*BW +: BW];
      v_sk_d[0] = rd_vld_q;
      for (int s = 1; s < gi; s++) begin
        a_sk_d[s] = a_sk_q[s-1];
        b_sk_d[s] = b_sk_q[s-1];
        v_sk_d[s] = v_sk_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < gi; s++) begin
          a_sk_q[s] <= '0;
          b_sk_q[s] <= '0;
          v_sk_q[s] <= 1'b0;
        end
      end else begin
        for (int s = 0; s < gi; s++) begin
          a_sk_q[s] <= a_sk_d[s];
          b_sk_q[s] <= b_sk_d[s];
          v_sk_q[s] <= v_sk_d[s];
        end
      end
    end

    assign v_west[gi]             = v_sk_q[gi-1];
    assign v_north[gi]            = v_sk_q[gi-1];
    assign a_west[gi*BW +: BW]    = v_sk_q[gi-1] ? a_sk_q[gi-1] : '0;
    assign b_north[gi*BW +: BW]   = v_sk_q[gi-1] ? b_sk_q[gi-1] : '0;
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] busy_cyc_q, busy_cyc_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;

  always_comb begin
    busy_cyc_d  = busy_cyc_q;
    stall_cyc_d = stall_cyc_q;
    if (state_q == S_IDLE && start) begin
      busy_cyc_d  = '0;
      stall_cyc_d = '0;
    end else begin
      if (busy && busy_cyc_q != '1)
        busy_cyc_d = busy_cyc_q + 32'd1;
      if (out_phase && !res_ready && stall_cyc_q != '1)
        stall_cyc_d = stall_cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      busy_cyc_q  <= busy_cyc_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign perf_busy_cyc  = busy_cyc_q;
  assign perf_stall_cyc = stall_cyc_q;
`endif

endmodule
